pattern_detect_reg: RTL and testbench
=====================================

Name: pattern_detect_reg

Overview:
- Output-register stage directly downstream of the combinational mask/pattern comparator in the DSP48E1 model.
- Registers the 48-bit ALU result and the comparator's raw PD/PBD flags.
- Derives PATTERNDETECT, PATTERNBDETECT, OVERFLOW and UNDERFLOW.
- Applies the AUTORESET_PATDET clear to the P register; feeds the top-level P and flag outputs.

Parameters:
- PREG, 1, 1 = registered outputs; 0 = combinational pass-through.
- USE_PATTERN_DETECT, "PATDET", "PATDET" enables flag logic; "NO_PATDET" forces all flag outputs to 0.
- AUTORESET_PATDET, "NO_RESET", one of "NO_RESET", "RESET_MATCH", "RESET_NOT_MATCH".

Ports:
- CLK  input  1  Clock; all state updates on the rising edge.
- RSTP  input  1  Synchronous active-high reset of the P/flag registers.
- CEP  input  1  Clock enable for all registers in this block.
- P_IN  input  48  Signed ALU output, the same value the comparator evaluates.
- PD  input  1  Raw pattern match from the comparator.
- PBD  input  1  Raw pattern-bar match from the comparator.
- P  output  48  Registered (or pass-through) result.
- PATTERNDETECT  output  1  Registered PD.
- PATTERNBDETECT  output  1  Registered PBD.
- OVERFLOW  output  1  Match lost since the previous cycle.
- UNDERFLOW  output  1  Bar-match lost since the previous cycle.

Behaviour:
- Clock and reset: single clock CLK; reset RSTP is synchronous and active-high.
- Internal state (PREG=1): P_REG[47:0], PD_REG, PBD_REG, PD_PAST, PBD_PAST.
- RSTP=1 at an edge: all five registers cleared to 0, regardless of CEP. RSTP has priority over autoreset and CEP. Outputs are therefore all 0 after reset.
- CEP=0 and RSTP=0: all registers hold.
- CEP=1 and RSTP=0:
  - PD_PAST<=PD_REG; PBD_PAST<=PBD_REG.
  - PD_REG<=PD; PBD_REG<=PBD.
  - P_REG<=0 if AR=1, else P_IN.
- Autoreset term AR, evaluated from pre-edge register values:
  - NO_RESET: AR=0.
  - RESET_MATCH: AR=PD_REG.
  - RESET_NOT_MATCH: AR=PD_PAST & ~PD_REG.
- Autoreset clears P_REG only. Flag and past registers load normally, so OVERFLOW/UNDERFLOW are never produced by the clear itself.
- Latency PREG=1: one cycle from P_IN/PD/PBD to P/PATTERNDETECT/PATTERNBDETECT.
- OVERFLOW = PD_PAST & ~PD_REG & ~PBD_REG, combinational from registers.
- UNDERFLOW = PBD_PAST & ~PD_REG & ~PBD_REG.
- PD_REG and PBD_REG both 1: legal only when the mask is all ones. Propagate it; OVERFLOW and UNDERFLOW are then 0.
- USE_PATTERN_DETECT="NO_PATDET":
  - PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW tied 0.
  - AR forced 0; P path unaffected.
- PREG=0:
  - P=P_IN, PATTERNDETECT=PD, PATTERNBDETECT=PBD (0 if NO_PATDET).
  - OVERFLOW=UNDERFLOW=0; no registers inferred; CLK/RSTP/CEP ignored.
- Invalid AUTORESET_PATDET string: behave as NO_RESET; simulation prints an error at time 0.
- No X propagation from unused inputs when disabled.

Test Plan:
- Reset: drive P_IN=48'h1234, PD=1, CEP=1, RSTP=1 for 2 edges -> P=0, PATTERNDETECT=0, OVERFLOW=0.
- Latency and CE:
  - RSTP=0, CEP=1, P_IN=48'hA5A5 with PD=1 -> next edge P=48'hA5A5, PATTERNDETECT=1.
  - CEP=0 for 3 edges with P_IN changing -> outputs hold.
- Overflow:
  - Counter sequence with PD=1,1,0 (PBD=0) -> after the third edge OVERFLOW=1 for exactly one cycle, UNDERFLOW=0.
  - Mirror with PBD=1,0 -> UNDERFLOW pulse.
- RESET_MATCH:
  - P_IN=5, PD=1 at edge n -> P=5 at n.
  - At edge n+1, P_IN=6 -> P=0.
  - At edge n+2, P_IN=7, PD=0 -> P=7.
- RESET_NOT_MATCH:
  - PD=1 at edge n, PD=0 at edge n+1 -> edge n+2 P=0 despite P_IN=9.
  - PD held 1 -> no clear.
- Priority and modes:
  - RSTP=1 while AR=1 and CEP=0 -> all registers 0.
  - PREG=0 build: P follows P_IN same cycle, OVERFLOW stuck 0.

Source files
------------

// File: rtl/pattern_detect_reg.sv
// Output register stage behind the DSP pattern comparator.
// Holds P and the PD/PBD flags, derives over/underflow and autoreset.
module pattern_detect_reg #(
   parameter int    PREG               = 1,
   parameter string USE_PATTERN_DETECT = "PATDET",
   parameter string AUTORESET_PATDET   = "NO_RESET"
) (
   input  logic        CLK,
   input  logic        RSTP,
   input  logic        CEP,
   input  logic [47:0] P_IN,
   input  logic        PD,
   input  logic        PBD,
   output logic [47:0] P,
   output logic        PATTERNDETECT,
   output logic        PATTERNBDETECT,
   output logic        OVERFLOW,
   output logic        UNDERFLOW
);

   localparam bit PATDET_EN = (USE_PATTERN_DETECT == "PATDET");

   localparam bit AR_KNOWN =
      (AUTORESET_PATDET == "NO_RESET") ||
      (AUTORESET_PATDET == "RESET_MATCH") ||
      (AUTORESET_PATDET == "RESET_NOT_MATCH");

   localparam bit AR_MATCH =
      PATDET_EN && (AUTORESET_PATDET == "RESET_MATCH");

   localparam bit AR_NOT_MATCH =
      PATDET_EN && (AUTORESET_PATDET == "RESET_NOT_MATCH");

   // With detection off, PD/PBD are masked so X never reaches state.
   logic pd_in;
   logic pbd_in;

   assign pd_in  = PATDET_EN ? PD  : 1'b0;
   assign pbd_in = PATDET_EN ? PBD : 1'b0;

   if (!AR_KNOWN) begin : g_bad_ar
      $error("pattern_detect_reg: unknown AUTORESET_PATDET value");
   end

   if (PREG != 0) begin : g_reg
      logic [47:0] p_reg;
      logic        pd_reg;
      logic        pbd_reg;
      logic        pd_past;
      logic        pbd_past;
      logic        ar;

      always_comb begin
         ar = 1'b0;
         if (AR_MATCH)
            ar = pd_reg;
         if (AR_NOT_MATCH)
            ar = pd_past & ~pd_reg;
      end

      // Autoreset clears only P; flags keep loading normally.
      always_ff @(posedge CLK) begin
         if (RSTP) begin
            p_reg    <= '0;
            pd_reg   <= 1'b0;
            pbd_reg  <= 1'b0;
            pd_past  <= 1'b0;
            pbd_past <= 1'b0;
         end else if (CEP) begin
            pd_past  <= pd_reg;
            pbd_past <= pbd_reg;
            pd_reg   <= pd_in;
            pbd_reg  <= pbd_in;
            p_reg    <= ar ? '0 : P_IN;
         end
      end

      assign P              = p_reg;
      assign PATTERNDETECT  = pd_reg;
      assign PATTERNBDETECT = pbd_reg;
      assign OVERFLOW       = pd_past & ~pd_reg & ~pbd_reg;
      assign UNDERFLOW      = pbd_past & ~pd_reg & ~pbd_reg;
   end else begin : g_comb
      logic unused_ctl;

      assign unused_ctl     = ^{CLK, RSTP, CEP};
      assign P              = P_IN;
      assign PATTERNDETECT  = pd_in;
      assign PATTERNBDETECT = pbd_in;
      assign OVERFLOW       = 1'b0;
      assign UNDERFLOW      = 1'b0;
   end

endmodule

// File: tb/tb_pattern_detect_reg.sv
// Directed bench for pattern_detect_reg across its build variants.
// All variants share one stimulus stream; each is checked separately.
module tb_pattern_detect_reg;

   logic        clk;
   logic        rstp;
   logic        cep;
   logic [47:0] p_in;
   logic        pd;
   logic        pbd;

   int checks;
   int errors;

   logic [47:0] nr_p,  rm_p,  rnm_p,  cb_p,  np_p;
   logic        nr_pd, rm_pd, rnm_pd, cb_pd, np_pd;
   logic        nr_pb, rm_pb, rnm_pb, cb_pb, np_pb;
   logic        nr_ov, rm_ov, rnm_ov, cb_ov, np_ov;
   logic        nr_un, rm_un, rnm_un, cb_un, np_un;

   pattern_detect_reg #(
      .PREG(1), .USE_PATTERN_DETECT("PATDET"),
      .AUTORESET_PATDET("NO_RESET")
   ) u_nr (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in),
      .PD(pd), .PBD(pbd), .P(nr_p), .PATTERNDETECT(nr_pd),
      .PATTERNBDETECT(nr_pb), .OVERFLOW(nr_ov), .UNDERFLOW(nr_un)
   );

   pattern_detect_reg #(
      .PREG(1), .USE_PATTERN_DETECT("PATDET"),
      .AUTORESET_PATDET("RESET_MATCH")
   ) u_rm (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in),
      .PD(pd), .PBD(pbd), .P(rm_p), .PATTERNDETECT(rm_pd),
      .PATTERNBDETECT(rm_pb), .OVERFLOW(rm_ov), .UNDERFLOW(rm_un)
   );

   pattern_detect_reg #(
      .PREG(1), .USE_PATTERN_DETECT("PATDET"),
      .AUTORESET_PATDET("RESET_NOT_MATCH")
   ) u_rnm (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in),
      .PD(pd), .PBD(pbd), .P(rnm_p), .PATTERNDETECT(rnm_pd),
      .PATTERNBDETECT(rnm_pb), .OVERFLOW(rnm_ov), .UNDERFLOW(rnm_un)
   );

   pattern_detect_reg #(
      .PREG(0), .USE_PATTERN_DETECT("PATDET"),
      .AUTORESET_PATDET("NO_RESET")
   ) u_cb (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in),
      .PD(pd), .PBD(pbd), .P(cb_p), .PATTERNDETECT(cb_pd),
      .PATTERNBDETECT(cb_pb), .OVERFLOW(cb_ov), .UNDERFLOW(cb_un)
   );

   pattern_detect_reg #(
      .PREG(1), .USE_PATTERN_DETECT("NO_PATDET"),
      .AUTORESET_PATDET("RESET_MATCH")
   ) u_np (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in),
      .PD(pd), .PBD(pbd), .P(np_p), .PATTERNDETECT(np_pd),
      .PATTERNBDETECT(np_pb), .OVERFLOW(np_ov), .UNDERFLOW(np_un)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_w(input string tag,
                        input logic [47:0] obs,
                        input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag,
                        input logic obs,
                        input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rstp = 1'b1;
      cep  = 1'b1;
      step();
      rstp = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Reset held for two edges with live data on the inputs.
      rstp = 1'b1;
      cep  = 1'b1;
      p_in = 48'h1234;
      pd   = 1'b1;
      pbd  = 1'b0;
      step();
      step();
      chk_w("rst_p",     nr_p,  48'h0);
      chk_b("rst_pd",    nr_pd, 1'b0);
      chk_b("rst_ov",    nr_ov, 1'b0);
      chk_b("rst_un",    nr_un, 1'b0);
      chk_w("rst_rm_p",  rm_p,  48'h0);
      chk_w("rst_cb_p",  cb_p,  48'h1234);
      chk_b("rst_cb_pd", cb_pd, 1'b1);

      // One-cycle latency.
      rstp = 1'b0;
      p_in = 48'hA5A5;
      pd   = 1'b1;
      step();
      chk_w("lat_p",     nr_p,  48'hA5A5);
      chk_b("lat_pd",    nr_pd, 1'b1);
      chk_w("lat_rm_p",  rm_p,  48'hA5A5);
      chk_w("lat_np_p",  np_p,  48'hA5A5);
      chk_b("lat_np_pd", np_pd, 1'b0);

      // Clock enable low: hold for three edges.
      cep = 1'b0;
      for (int i = 0; i < 3; i++) begin
         p_in = 48'h100 + 48'(i);
         pd   = 1'b0;
         step();
         chk_w("ce_hold_p",  nr_p,  48'hA5A5);
         chk_b("ce_hold_pd", nr_pd, 1'b1);
         chk_w("ce_cb_p",    cb_p,  48'h100 + 48'(i));
      end

      // Overflow: PD 1,1,0.
      do_reset();
      pbd  = 1'b0;
      pd   = 1'b1;
      p_in = 48'd1;
      step();
      p_in = 48'd2;
      step();
      chk_b("ovf_pre", nr_ov, 1'b0);
      pd   = 1'b0;
      p_in = 48'd3;
      step();
      chk_b("ovf_hit",    nr_ov, 1'b1);
      chk_b("ovf_un",     nr_un, 1'b0);
      chk_w("ovf_p",      nr_p,  48'd3);
      chk_b("ovf_np",     np_ov, 1'b0);
      chk_b("ovf_cb",     cb_ov, 1'b0);
      p_in = 48'd4;
      step();
      chk_b("ovf_clear",  nr_ov, 1'b0);

      // Underflow: PBD 1,0.
      do_reset();
      pd   = 1'b0;
      pbd  = 1'b1;
      step();
      chk_b("unf_pre", nr_un, 1'b0);
      chk_b("unf_pb",  nr_pb, 1'b1);
      pbd  = 1'b0;
      step();
      chk_b("unf_hit", nr_un, 1'b1);
      chk_b("unf_ov",  nr_ov, 1'b0);
      step();
      chk_b("unf_clear", nr_un, 1'b0);

      // PD and PBD both set: propagate, no over/underflow.
      pd  = 1'b1;
      pbd = 1'b1;
      step();
      step();
      chk_b("both_pd", nr_pd, 1'b1);
      chk_b("both_pb", nr_pb, 1'b1);
      chk_b("both_ov", nr_ov, 1'b0);
      chk_b("both_un", nr_un, 1'b0);

      // RESET_MATCH: PD only at edge n.
      do_reset();
      pbd  = 1'b0;
      pd   = 1'b1;
      p_in = 48'd5;
      step();
      chk_w("rm_n",  rm_p, 48'd5);
      pd   = 1'b0;
      p_in = 48'd6;
      step();
      chk_w("rm_n1",    rm_p, 48'd0);
      chk_w("rm_nr_n1", nr_p, 48'd6);
      chk_w("rm_np_n1", np_p, 48'd6);
      p_in = 48'd7;
      step();
      chk_w("rm_n2", rm_p, 48'd7);

      // RESET_NOT_MATCH: PD 1 then 0 clears P one edge later.
      do_reset();
      pd   = 1'b1;
      p_in = 48'd8;
      step();
      pd   = 1'b0;
      step();
      chk_w("rnm_n1",    rnm_p,  48'd8);
      chk_b("rnm_ov_n1", rnm_ov, 1'b1);
      p_in = 48'd9;
      step();
      chk_w("rnm_n2",    rnm_p,  48'd0);
      chk_w("rnm_nr_n2", nr_p,   48'd9);
      chk_b("rnm_ov_n2", rnm_ov, 1'b0);

      // RESET_NOT_MATCH with PD held high never clears.
      do_reset();
      pd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         p_in = 48'd10 + 48'(i);
         step();
         chk_w("rnm_hold", rnm_p, 48'd10 + 48'(i));
      end

      // Reset wins over pending autoreset with CEP low.
      do_reset();
      pd   = 1'b1;
      p_in = 48'h77;
      step();
      chk_w("pri_pre", rm_p, 48'h77);
      cep  = 1'b0;
      rstp = 1'b1;
      step();
      chk_w("pri_rm_p",  rm_p,  48'h0);
      chk_b("pri_rm_pd", rm_pd, 1'b0);
      chk_w("pri_nr_p",  nr_p,  48'h0);
      rstp = 1'b0;

      // Pass-through build follows inputs without a clock.
      p_in = 48'hDEAD_BEEF_0001;
      pd   = 1'b0;
      pbd  = 1'b1;
      #2;
      chk_w("cb_p",  cb_p,  48'hDEAD_BEEF_0001);
      chk_b("cb_pb", cb_pb, 1'b1);
      chk_b("cb_ov", cb_ov, 1'b0);
      chk_b("cb_un", cb_un, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
